// File: rtl/fifo_frame_reader.sv
// Drain side of the asynchronous sample FIFO: waits for a whole frame, bursts it out
// through a 4-entry skid buffer onto a valid/ready stream with SOF/EOF markers.
module fifo_frame_reader #(
    parameter int DATA_WIDTH  = 10,
    parameter int LEVEL_WIDTH = 14,
    parameter int FRAME_LEN   = 1024,
    parameter bit CONT_MODE   = 1'b0
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_sof,
    output logic                   m_eof,
    output logic                   busy,
    output logic                   frame_done,
    output logic [15:0]            underrun_cnt
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]       CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [LEVEL_WIDTH-1:0] LVL_NEED = LEVEL_WIDTH'(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, WAIT_LVL, BURST, DRAIN} state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   lvl_ok_p1;
    logic [CNT_W-1:0]       issued_q;
    logic [CNT_W-1:0]       out_cnt_q;
    logic                   vld_p1;
    logic [2:0]             buf_cnt;
    logic [1:0]             wr_ptr;
    logic [1:0]             rd_ptr;
    logic [DATA_WIDTH-1:0]  buf_mem [0:3];

    logic credit_ok;
    logic issue_req;
    logic underrun_hit;
    logic pop;
    logic last_pop;

    // Credit counts the read still in flight so the buffer can never overflow.
    assign credit_ok    = (buf_cnt + {2'b00, vld_p1}) <= 3'd2;
    assign issue_req    = (state_q == BURST) && (issued_q < CNT_FULL);
    assign fifo_rd_en   = issue_req && credit_ok && !fifo_rd_empty;
    assign underrun_hit = issue_req && credit_ok && fifo_rd_empty;

    assign m_valid  = (buf_cnt != 3'd0);
    assign m_data   = m_valid ? buf_mem[rd_ptr] : '0;
    assign m_sof    = m_valid && (out_cnt_q == '0);
    assign m_eof    = m_valid && (out_cnt_q == CNT_LAST);
    assign pop      = m_valid && m_ready;
    assign last_pop = pop && (out_cnt_q == CNT_LAST);
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (start || CONT_MODE) state_d = WAIT_LVL;
                WAIT_LVL: if (lvl_ok_p1) state_d = BURST;
                BURST:    if (issued_q == CNT_FULL) state_d = DRAIN;
                DRAIN:    if (last_pop) state_d = CONT_MODE ? WAIT_LVL : IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q      <= IDLE;
            lvl_ok_p1    <= 1'b0;
            issued_q     <= '0;
            out_cnt_q    <= '0;
            vld_p1       <= 1'b0;
            buf_cnt      <= 3'd0;
            wr_ptr       <= 2'd0;
            rd_ptr       <= 2'd0;
            frame_done   <= 1'b0;
            underrun_cnt <= 16'd0;
        end else begin
            state_q    <= state_d;
            lvl_ok_p1  <= !abort && (state_q == WAIT_LVL) && (fifo_rd_water_level >= LVL_NEED);
            frame_done <= last_pop && !abort;
            if (underrun_hit && (underrun_cnt != 16'hFFFF))
                underrun_cnt <= underrun_cnt + 16'd1;

            if (abort) begin
                issued_q  <= '0;
                out_cnt_q <= '0;
                vld_p1    <= 1'b0;
                buf_cnt   <= 3'd0;
                wr_ptr    <= 2'd0;
                rd_ptr    <= 2'd0;
            end else begin
                vld_p1 <= fifo_rd_en;
                if ((state_q == IDLE) || last_pop) begin
                    issued_q  <= '0;
                    out_cnt_q <= '0;
                end else begin
                    if (fifo_rd_en) issued_q  <= issued_q + CNT_W'(1);
                    if (pop)        out_cnt_q <= out_cnt_q + CNT_W'(1);
                end
                if (vld_p1) wr_ptr <= wr_ptr + 2'd1;
                if (pop)    rd_ptr <= rd_ptr + 2'd1;
                case ({vld_p1, pop})
                    2'b10:   buf_cnt <= buf_cnt + 3'd1;
                    2'b01:   buf_cnt <= buf_cnt - 3'd1;
                    default: buf_cnt <= buf_cnt;
                endcase
            end
        end
    end

    // p1: FIFO data returns one cycle after the read; an abort drops it.
    always_ff @(posedge rd_clk) begin
        if (vld_p1 && !abort)
            buf_mem[wr_ptr] <= fifo_rd_data;
    end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader: one single-shot and one continuous instance,
// each fed by a behavioural FIFO with one-cycle read latency.
module tb_fifo_frame_reader;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instance 0: single-shot, FRAME_LEN 16
    logic        start0, abort0, rd_en0, empty0, m_valid0, m_ready0, sof0, eof0, busy0, fd0;
    logic        force_empty0;
    logic [9:0]  rd_data0, m_data0;
    logic [13:0] lvl0;
    logic [15:0] urun0;
    logic [9:0]  fmem0 [0:255];
    int          wr0 = 0;
    int          rd0 = 0;

    assign empty0 = (wr0 == rd0) || force_empty0;
    assign lvl0   = 14'(wr0 - rd0);
    always @(posedge clk) if (rd_en0) begin
        rd_data0 <= fmem0[rd0[7:0]];
        rd0      <= rd0 + 1;
    end

    fifo_frame_reader #(.DATA_WIDTH(10), .LEVEL_WIDTH(14), .FRAME_LEN(16), .CONT_MODE(1'b0)) u0 (
        .rd_clk(clk), .rd_rst_n(rst_n), .start(start0), .abort(abort0),
        .fifo_rd_en(rd_en0), .fifo_rd_data(rd_data0), .fifo_rd_empty(empty0),
        .fifo_rd_water_level(lvl0), .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready0),
        .m_sof(sof0), .m_eof(eof0), .busy(busy0), .frame_done(fd0), .underrun_cnt(urun0)
    );

    // Instance 1: continuous mode, FRAME_LEN 16
    logic        start1, abort1, rd_en1, empty1, m_valid1, m_ready1, sof1, eof1, busy1, fd1;
    logic [9:0]  rd_data1, m_data1;
    logic [13:0] lvl1;
    logic [15:0] urun1;
    logic [9:0]  fmem1 [0:255];
    int          wr1 = 0;
    int          rd1 = 0;

    assign empty1 = (wr1 == rd1);
    assign lvl1   = 14'(wr1 - rd1);
    always @(posedge clk) if (rd_en1) begin
        rd_data1 <= fmem1[rd1[7:0]];
        rd1      <= rd1 + 1;
    end

    fifo_frame_reader #(.DATA_WIDTH(10), .LEVEL_WIDTH(14), .FRAME_LEN(16), .CONT_MODE(1'b1)) u1 (
        .rd_clk(clk), .rd_rst_n(rst_n), .start(start1), .abort(abort1),
        .fifo_rd_en(rd_en1), .fifo_rd_data(rd_data1), .fifo_rd_empty(empty1),
        .fifo_rd_water_level(lvl1), .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1),
        .m_sof(sof1), .m_eof(eof1), .busy(busy1), .frame_done(fd1), .underrun_cnt(urun1)
    );

    task automatic push(input bit which, input int n);
        for (int i = 0; i < n; i++) begin
            if (which) begin
                fmem1[wr1[7:0]] = 10'(wr1);
                wr1 = wr1 + 1;
            end else begin
                fmem0[wr0[7:0]] = 10'(wr0);
                wr0 = wr0 + 1;
            end
            tick();
        end
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    // Stream scoreboard for instance 0: sample values equal their FIFO write index.
    int   exp0 = 0, pos0 = 0, beats0 = 0, fd_cnt0 = 0, rd_total0 = 0, eof_cyc0 = 0, max_buf0 = 0;
    logic stall0 = 1'b0, resync0 = 1'b0;
    logic [9:0] held0 = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall0  = 1'b0;
                resync0 = 1'b0;
            end else begin
                if (resync0) begin
                    exp0    = rd0;
                    pos0    = 0;
                    resync0 = 1'b0;
                end
                if (rd_en0) begin
                    rd_total0++;
                    check("rd_en_while_empty", 32'(empty0), 32'd0);
                end
                if (stall0) begin
                    check("stall_valid", 32'(m_valid0), 32'd1);
                    check("stall_data", 32'(m_data0), 32'(held0));
                end
                if (m_valid0 && m_ready0) begin
                    check("data0", 32'(m_data0), 32'(exp0));
                    check("sof0", 32'(sof0), 32'(pos0 == 0));
                    check("eof0", 32'(eof0), 32'(pos0 == 15));
                    if (eof0) eof_cyc0 = cyc;
                    exp0++;
                    pos0 = (pos0 == 15) ? 0 : pos0 + 1;
                    beats0++;
                end
                stall0 = m_valid0 && !m_ready0 && !abort0;
                held0  = m_data0;
                if (fd0) begin
                    fd_cnt0++;
                    check("fd_latency", 32'(cyc - eof_cyc0), 32'd1);
                    check("fd_busy_low", 32'(busy0), 32'd0);
                end
                if (int'(u0.buf_cnt) > max_buf0) max_buf0 = int'(u0.buf_cnt);
                if (abort0) resync0 = 1'b1;
            end
        end
    end

    int exp1 = 0, pos1 = 0, beats1 = 0, fd_cnt1 = 0, sof_cnt1 = 0, eof_cnt1 = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m_valid1 && m_ready1) begin
                    check("data1", 32'(m_data1), 32'(exp1));
                    check("sof1", 32'(sof1), 32'(pos1 == 0));
                    check("eof1", 32'(eof1), 32'(pos1 == 15));
                    if (sof1) sof_cnt1++;
                    if (eof1) eof_cnt1++;
                    exp1++;
                    pos1 = (pos1 == 15) ? 0 : pos1 + 1;
                    beats1++;
                end
                if (fd1) fd_cnt1++;
            end
        end
    end

    task automatic wait_fd0(input int target, input int budget, input string tag);
        int n = 0;
        while (fd_cnt0 < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(fd_cnt0), 32'(target));
    endtask

    initial begin
        int sc, frd, rc, fr, b, n;
        rst_n = 1'b0; start0 = 1'b0; abort0 = 1'b0; m_ready0 = 1'b1; force_empty0 = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; m_ready1 = 1'b1;
        repeat (3) tick();
        check("rst_rd_en", 32'(rd_en0), 32'd0);
        check("rst_valid", 32'(m_valid0), 32'd0);
        check("rst_sof_eof", 32'({sof0, eof0}), 32'd0);
        check("rst_busy", 32'({busy0, busy1}), 32'd0);
        check("rst_frame_done", 32'(fd0), 32'd0);
        check("rst_data", 32'(m_data0), 32'd0);
        check("rst_underrun", 32'(urun0), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic frame with latency checks
        push(1'b0, 20);
        sc = cyc;
        pulse_start0();
        n = 0;
        while (!rd_en0 && n < 20) begin tick(); n++; end
        frd = cyc;
        check("lat_first_read", 32'(frd - sc), 32'd3);
        n = 0;
        while (!m_valid0 && n < 20) begin tick(); n++; end
        check("lat_first_valid", 32'(cyc - frd), 32'd2);
        wait_fd0(1, 200, "t1_frame_done");
        check("t1_beats", 32'(beats0), 32'd16);
        check("t1_frame_cycles", 32'(eof_cyc0 - frd), 32'd17);
        check("t1_left_in_fifo", 32'(lvl0), 32'd4);
        check("t1_underrun", 32'(urun0), 32'd0);

        // Level gating: 10 samples present, the rest arrive later
        push(1'b0, 6);
        rc = rd_total0;
        pulse_start0();
        repeat (50) tick();
        check("t2_no_read_early", 32'(rd_total0 - rc), 32'd0);
        check("t2_busy_waiting", 32'(busy0), 32'd1);
        push(1'b0, 6);
        wait_fd0(2, 200, "t2_frame_done");
        check("t2_beats", 32'(beats0), 32'd32);

        // Backpressure at ~30% ready
        push(1'b0, 16);
        pulse_start0();
        n = 0;
        while (fd_cnt0 < 3 && n < 600) begin
            m_ready0 = ($urandom_range(0, 9) < 3);
            tick();
            n++;
        end
        m_ready0 = 1'b1;
        check("t3_frame_done", 32'(fd_cnt0), 32'd3);
        check("t3_beats", 32'(beats0), 32'd48);
        check("t3_max_buf", 32'(max_buf0 <= 3), 32'd1);

        // Underrun: empty forced for 5 cycles mid-burst
        push(1'b0, 16);
        rc = rd_total0;
        pulse_start0();
        n = 0;
        while ((rd_total0 - rc) < 5 && n < 50) begin tick(); n++; end
        force_empty0 = 1'b1;
        fr = rd_total0;
        repeat (5) tick();
        force_empty0 = 1'b0;
        check("t4_no_read_forced", 32'(rd_total0 - fr), 32'd0);
        wait_fd0(4, 200, "t4_frame_done");
        check("t4_underrun", 32'(urun0), 32'd5);
        check("t4_beats", 32'(beats0), 32'd64);

        // Abort after 7 beats, then a clean restart
        push(1'b0, 20);
        b = beats0;
        pulse_start0();
        n = 0;
        while ((beats0 - b) < 7 && n < 100) begin tick(); n++; end
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        check("t5_idle_after_abort", 32'(busy0), 32'd0);
        check("t5_valid_after_abort", 32'(m_valid0), 32'd0);
        push(1'b0, 16);
        b = beats0;
        pulse_start0();
        wait_fd0(5, 200, "t5_frame_done");
        check("t5_restart_beats", 32'(beats0 - b), 32'd16);

        // Continuous mode: three frames back to back
        push(1'b1, 48);
        n = 0;
        while (fd_cnt1 < 3 && n < 300) begin tick(); n++; end
        check("t6_frames", 32'(fd_cnt1), 32'd3);
        check("t6_sof_count", 32'(sof_cnt1), 32'd3);
        check("t6_eof_count", 32'(eof_cnt1), 32'd3);
        check("t6_beats", 32'(beats1), 32'd48);
        check("t6_still_armed", 32'(busy1), 32'd1);
        check("t6_underrun", 32'(urun1), 32'd0);

        // Reset asserted mid-frame clears outputs without a clock edge
        push(1'b0, 16);
        b = beats0;
        pulse_start0();
        n = 0;
        while ((beats0 - b) < 3 && n < 100) begin tick(); n++; end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t7_rd_en", 32'(rd_en0), 32'd0);
        check("t7_valid", 32'(m_valid0), 32'd0);
        check("t7_sof_eof", 32'({sof0, eof0}), 32'd0);
        check("t7_busy", 32'({busy0, busy1}), 32'd0);
        check("t7_frame_done", 32'(fd0), 32'd0);
        check("t7_data", 32'(m_data0), 32'd0);
        check("t7_underrun", 32'(urun0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
